change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters SHALL be: STOCK10, default 8, reset/refill count of 10-dollar coins; STOCK5, default 8, reset/refill count of 5-dollar coins; STOCK1, default 32, reset/refill count of 1-dollar coins.
REQ-002 Clocking and reset SHALL be: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-003 Ports SHALL be, name direction width meaning:
  clk  in  1  clock, rising edge;
  reset  in  1  asynchronous active-high reset;
  change_valid  in  1  change request strobe;
  change_amount  in  8  dollars owed, unsigned;
  refill  in  1  reload all stock counters;
  coin_ready  in  1  hopper accepts the presented coin;
  coin_valid  out  1  coin presented;
  coin_out  out  8  denomination presented (10, 5, 1), 0 when coin_valid=0;
  busy  out  1  request in progress;
  done  out  1  one-cycle completion pulse;
  short  out  1  shortfall flag, meaningful with done;
  remain  out  8  dollars still owed;
  stock10, stock5, stock1  out  8 each  coins on hand.

Function
REQ-004 The block SHALL be a Moore FSM with states IDLE, SELECT, DISPENSE, FINISH; all outputs SHALL be registered or decoded from state and registers only.
REQ-005 IDLE: busy=0, coin_valid=0, done=0; on change_valid=1 the block SHALL latch change_amount into remain and go to SELECT; change_valid outside IDLE SHALL be ignored.
REQ-006 SELECT: if remain=0, the block SHALL go to FINISH with short=0; otherwise it SHALL pick the largest d in {10, 5, 1} with d<=remain and stock_d>0, load coin_out=d, and go to DISPENSE; if no such d exists, it SHALL go to FINISH with short=1.
REQ-007 DISPENSE: coin_valid=1, and coin_out SHALL stay stable until coin_ready=1; on an edge with coin_valid&coin_ready, the block SHALL perform remain-=d and stock_d-=1, then go to SELECT.
REQ-008 Minimum coin spacing SHALL be 2 cycles; the first coin_valid SHALL appear 2 edges after the edge that sampled change_valid.
REQ-009 FINISH: done=1 for exactly one cycle, short as decided in SELECT, remain holds the final value; the next state SHALL be IDLE, with short and remain held until the next accepted request.
REQ-010 busy SHALL be 1 in SELECT, DISPENSE and FINISH.
REQ-011 A request with change_amount=0 SHALL reach FINISH via SELECT with no coin, done=1, and short=0.
REQ-012 refill SHALL be honoured only in IDLE and SHALL set stock counters to STOCK10/STOCK5/STOCK1; if refill and change_valid coincide, both SHALL take effect and selection SHALL use the reloaded stock.
REQ-013 No stock counter or remain SHALL ever decrement below 0; arithmetic SHALL be 8-bit unsigned without wrap.

Reset
REQ-014 reset=1 SHALL immediately force state IDLE, coin_valid=0, coin_out=0, busy=0, done=0, short=0, remain=0, and stock10/5/1 = STOCK10/STOCK5/STOCK1, including mid-dispense; a coin presented but not yet accepted SHALL be discarded.

Verification
REQ-015 Defaults, coin_ready=1, request 6 -> coins 5 then 1; done with short=0, remain=0, stock5=7, stock1=31.
REQ-016 Request 26 -> coins 10, 10, 5, 1; done with short=0; stock10=6.
REQ-017 STOCK10=1, request 26 -> coins 10, 5, 5, 5, 1; done with short=0.
REQ-018 Request 15, coin_ready held low for 3 cycles on the first coin -> coin_valid=1 and coin_out=10 stable, remain=15 until accept; then coin 5.
REQ-019 STOCK10=0, STOCK1=0, request 7 -> coin 5; done with short=1, remain=2, stock5=7.
REQ-020 reset asserted while coin_valid=1 during request 26 -> all outputs at reset values at once; a following request 6 is dispensed normally.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change FSM (10/5/1 dollar coins) with finite stock.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   change_valid            request strobe, sampled only in IDLE
//   change_amount[7:0]      dollars owed for the request
//   refill                  reload all stock counters (IDLE only)
//   coin_ready              hopper accepts the presented coin
//   coin_valid, coin_out    presented coin and its denomination (0 when none)
//   busy                    request in progress
//   done, short             one-cycle completion pulse and shortfall flag
//   remain[7:0]             dollars still owed
//   stock10/stock5/stock1   coins on hand
module change_dispenser #(
    parameter int unsigned STOCK10 = 8,
    parameter int unsigned STOCK5  = 8,
    parameter int unsigned STOCK1  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [7:0] change_amount,
    input  logic       refill,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [7:0] coin_out,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remain,
    output logic [7:0] stock10,
    output logic [7:0] stock5,
    output logic [7:0] stock1
);

    localparam logic [7:0] Init10 = 8'(STOCK10);
    localparam logic [7:0] Init5  = 8'(STOCK5);
    localparam logic [7:0] Init1  = 8'(STOCK1);

    typedef enum logic [1:0] {StIdle, StSelect, StDispense, StFinish} state_e;

    state_e     state_q;
    logic       cv_q;
    logic [7:0] coin_q;
    logic       busy_q;
    logic       done_q;
    logic       short_q;
    logic [7:0] remain_q;
    logic [7:0] s10_q;
    logic [7:0] s5_q;
    logic [7:0] s1_q;
    logic [7:0] pick_d;

    // Largest denomination that fits the remainder and is in stock; 0 if none.
    always_comb begin
        pick_d = 8'd0;
        if (remain_q >= 8'd10 && s10_q != 8'd0) begin
            pick_d = 8'd10;
        end else if (remain_q >= 8'd5 && s5_q != 8'd0) begin
            pick_d = 8'd5;
        end else if (remain_q != 8'd0 && s1_q != 8'd0) begin
            pick_d = 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cv_q     <= 1'b0;
            coin_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            remain_q <= 8'd0;
            s10_q    <= Init10;
            s5_q     <= Init5;
            s1_q     <= Init1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (refill) begin
                        s10_q <= Init10;
                        s5_q  <= Init5;
                        s1_q  <= Init1;
                    end
                    if (change_valid) begin
                        remain_q <= change_amount;
                        short_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StSelect;
                    end
                end
                StSelect: begin
                    if (remain_q == 8'd0) begin
                        short_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else if (pick_d != 8'd0) begin
                        coin_q  <= pick_d;
                        cv_q    <= 1'b1;
                        state_q <= StDispense;
                    end else begin
                        short_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StDispense: begin
                    if (coin_ready) begin
                        // coin_q <= remain_q and its stock was non-zero when picked.
                        remain_q <= remain_q - coin_q;
                        case (coin_q)
                            8'd10:   if (s10_q != 8'd0) s10_q <= s10_q - 8'd1;
                            8'd5:    if (s5_q != 8'd0) s5_q <= s5_q - 8'd1;
                            8'd1:    if (s1_q != 8'd0) s1_q <= s1_q - 8'd1;
                            default: ;
                        endcase
                        cv_q    <= 1'b0;
                        coin_q  <= 8'd0;
                        state_q <= StSelect;
                    end
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign coin_valid = cv_q;
    assign coin_out   = coin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remain     = remain_q;
    assign stock10    = s10_q;
    assign stock5     = s5_q;
    assign stock1     = s1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. Three instances with different stock
// parameters share all inputs; a transaction-level model plans each request's coin
// list greedily from its own stock copy and a negedge monitor checks every output.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic       refill = 1'b0;
    logic       coin_ready = 1'b1;

    logic       cv[3];
    logic [7:0] co[3];
    logic       bz[3];
    logic       dn[3];
    logic       sh[3];
    logic [7:0] rm[3];
    logic [7:0] st10[3];
    logic [7:0] st5[3];
    logic [7:0] st1[3];

    always #5 clk = ~clk;

    change_dispenser #(.STOCK10(8), .STOCK5(8), .STOCK1(32)) u_dut0 (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
        .refill(refill), .coin_ready(coin_ready), .coin_valid(cv[0]), .coin_out(co[0]),
        .busy(bz[0]), .done(dn[0]), .short(sh[0]), .remain(rm[0]),
        .stock10(st10[0]), .stock5(st5[0]), .stock1(st1[0]));

    change_dispenser #(.STOCK10(1), .STOCK5(8), .STOCK1(32)) u_dut1 (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
        .refill(refill), .coin_ready(coin_ready), .coin_valid(cv[1]), .coin_out(co[1]),
        .busy(bz[1]), .done(dn[1]), .short(sh[1]), .remain(rm[1]),
        .stock10(st10[1]), .stock5(st5[1]), .stock1(st1[1]));

    change_dispenser #(.STOCK10(0), .STOCK5(8), .STOCK1(0)) u_dut2 (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
        .refill(refill), .coin_ready(coin_ready), .coin_valid(cv[2]), .coin_out(co[2]),
        .busy(bz[2]), .done(dn[2]), .short(sh[2]), .remain(rm[2]),
        .stock10(st10[2]), .stock5(st5[2]), .stock1(st1[2]));

    int p10[3] = '{8, 1, 0};
    int p5[3]  = '{8, 8, 8};
    int p1[3]  = '{32, 32, 0};

    int n_chk = 0;
    int n_fail = 0;

    // Model state per instance. step: 0 idle, 1 deciding, 2 coin presented, 3 done pulse.
    int step[3];
    int qc[3][64];
    int qn[3];
    int qi[3];
    int m_rem[3];
    int m_short[3];
    int fin_short[3];
    int ms10[3];
    int ms5[3];
    int ms1[3];

    // Coins actually accepted, for literal checks in the directed tests.
    int log_c[3][64];
    int log_n[3];

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Greedy plan from the stock on hand: largest coin that fits and is available.
    task automatic plan(input int k, input int amt);
        int r, s10, s5, s1;
        r = amt; s10 = ms10[k]; s5 = ms5[k]; s1 = ms1[k];
        qn[k] = 0;
        forever begin
            if (r >= 10 && s10 > 0) begin qc[k][qn[k]] = 10; r -= 10; s10--; end
            else if (r >= 5 && s5 > 0) begin qc[k][qn[k]] = 5; r -= 5; s5--; end
            else if (r >= 1 && s1 > 0) begin qc[k][qn[k]] = 1; r -= 1; s1--; end
            else break;
            qn[k]++;
        end
        fin_short[k] = (r > 0) ? 1 : 0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                step[k] = 0; qn[k] = 0; qi[k] = 0; m_rem[k] = 0; m_short[k] = 0;
                ms10[k] = p10[k]; ms5[k] = p5[k]; ms1[k] = p1[k];
            end
            chk("busy", k, int'(bz[k]), (step[k] != 0) ? 1 : 0);
            chk("coin_valid", k, int'(cv[k]), (step[k] == 2) ? 1 : 0);
            chk("coin_out", k, int'(co[k]), (step[k] == 2) ? qc[k][qi[k]] : 0);
            chk("done", k, int'(dn[k]), (step[k] == 3) ? 1 : 0);
            chk("short", k, int'(sh[k]), m_short[k]);
            chk("remain", k, int'(rm[k]), m_rem[k]);
            chk("stock10", k, int'(st10[k]), ms10[k]);
            chk("stock5", k, int'(st5[k]), ms5[k]);
            chk("stock1", k, int'(st1[k]), ms1[k]);
            if (!reset) begin
                case (step[k])
                    0: begin
                        if (refill) begin
                            ms10[k] = p10[k]; ms5[k] = p5[k]; ms1[k] = p1[k];
                        end
                        if (change_valid) begin
                            plan(k, int'(change_amount));
                            qi[k] = 0; m_rem[k] = int'(change_amount); m_short[k] = 0;
                            step[k] = 1;
                        end
                    end
                    1: begin
                        if (qi[k] < qn[k]) step[k] = 2;
                        else begin m_short[k] = fin_short[k]; step[k] = 3; end
                    end
                    2: begin
                        if (coin_ready) begin
                            m_rem[k] -= qc[k][qi[k]];
                            case (qc[k][qi[k]])
                                10: ms10[k]--;
                                5: ms5[k]--;
                                default: ms1[k]--;
                            endcase
                            if (log_n[k] < 64) begin
                                log_c[k][log_n[k]] = qc[k][qi[k]];
                                log_n[k]++;
                            end
                            qi[k]++;
                            step[k] = 1;
                        end
                    end
                    default: step[k] = 0;
                endcase
            end
        end
    end

    task automatic clr_log();
        for (int k = 0; k < 3; k++) log_n[k] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
    endtask

    task automatic req(input int amt, input bit rf);
        clr_log();
        @(posedge clk); #2;
        change_valid = 1'b1; change_amount = 8'(amt); refill = rf;
        @(posedge clk); #2;
        change_valid = 1'b0; refill = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (!bz[0] && !bz[1] && !bz[2]) break;
        end
        if (i == 400) chk("idle_timeout", 0, 1, 0);
    endtask

    task automatic chk_log(input int k, input int n, input int c0, input int c1,
                           input int c2, input int c3, input int c4);
        int exp[5];
        exp = '{c0, c1, c2, c3, c4};
        chk("coin_count", k, log_n[k], n);
        for (int j = 0; j < n && j < 5; j++) chk("coin_seq", k, log_c[k][j], exp[j]);
    endtask

    initial begin
        do_reset();
        chk("reset_stock1", 0, int'(st1[0]), 32);

        // Request 6: first coin two edges after sampling, coins 5 then 1.
        req(6, 1'b0);
        @(negedge clk);
        chk("first_gap_cv", 0, int'(cv[0]), 0);
        chk("first_gap_busy", 0, int'(bz[0]), 1);
        @(negedge clk);
        chk("first_cv", 0, int'(cv[0]), 1);
        chk("first_coin", 0, int'(co[0]), 5);
        wait_idle();
        chk_log(0, 2, 5, 1, 0, 0, 0);
        chk("r6_short", 0, int'(sh[0]), 0);
        chk("r6_remain", 0, int'(rm[0]), 0);
        chk("r6_stock5", 0, int'(st5[0]), 7);
        chk("r6_stock1", 0, int'(st1[0]), 31);

        // Refill coinciding with a request: selection uses reloaded stock.
        req(6, 1'b1);
        wait_idle();
        chk("refill_stock5", 0, int'(st5[0]), 7);
        chk("refill_stock1", 0, int'(st1[0]), 31);

        // Zero request: done with no coin.
        req(0, 1'b0);
        wait_idle();
        chk("zero_coins", 0, log_n[0], 0);
        chk("zero_short", 0, int'(sh[0]), 0);

        // Request 26 on default and on STOCK10=1.
        do_reset();
        req(26, 1'b0);
        wait_idle();
        chk_log(0, 4, 10, 10, 5, 1, 0);
        chk("r26_short", 0, int'(sh[0]), 0);
        chk("r26_stock10", 0, int'(st10[0]), 6);
        chk_log(1, 5, 10, 5, 5, 5, 1);
        chk("r26_short", 1, int'(sh[1]), 0);

        // Request 7 with no tens and no ones: one 5, shortfall of 2.
        do_reset();
        req(7, 1'b0);
        wait_idle();
        chk_log(2, 1, 5, 0, 0, 0, 0);
        chk("r7_short", 2, int'(sh[2]), 1);
        chk("r7_remain", 2, int'(rm[2]), 2);
        chk("r7_stock5", 2, int'(st5[2]), 7);

        // Request 15 with the hopper stalled on the first coin.
        do_reset();
        coin_ready = 1'b0;
        req(15, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_cv", 0, int'(cv[0]), 1);
            chk("stall_coin", 0, int'(co[0]), 10);
            chk("stall_remain", 0, int'(rm[0]), 15);
        end
        @(posedge clk); #2 coin_ready = 1'b1;
        wait_idle();
        chk_log(0, 2, 10, 5, 0, 0, 0);

        // Reset while a coin is presented, then a normal request.
        do_reset();
        req(26, 1'b0);
        for (int i = 0; i < 20 && !cv[0]; i++) @(negedge clk);
        chk("pre_reset_cv", 0, int'(cv[0]), 1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("rst_cv", 0, int'(cv[0]), 0);
        chk("rst_coin", 0, int'(co[0]), 0);
        chk("rst_busy", 0, int'(bz[0]), 0);
        chk("rst_remain", 0, int'(rm[0]), 0);
        chk("rst_stock10", 0, int'(st10[0]), 8);
        @(posedge clk); #2 reset = 1'b0;
        req(6, 1'b0);
        wait_idle();
        chk_log(0, 2, 5, 1, 0, 0, 0);
        chk("post_rst_remain", 0, int'(rm[0]), 0);

        // Random traffic: requests and refills at any time, random hopper stalls, rare resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #2;
            change_valid  = ($urandom_range(0, 5) == 0);
            change_amount = 8'($urandom_range(0, 90));
            refill        = ($urandom_range(0, 15) == 0);
            coin_ready    = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #2;
        change_valid = 1'b0; refill = 1'b0; reset = 1'b0; coin_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
